ccff_bitstream_loader: RTL



---
 rtl/ccff_bitstream_loader_if.sv | 12 +
 rtl/ccff_bitstream_loader.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader_if.sv
// Host word stream into the configuration-chain loader: valid/ready handshake plus data word.
interface ccff_bitstream_loader_if #(
  parameter int WORD_WIDTH = 8
) ();
  logic                  din_valid;
  logic [WORD_WIDTH-1:0] din_data;
  logic                  din_ready;

  // Host side drives words, loader side answers with ready.
  modport master (output din_valid, output din_data, input din_ready);
  modport slave  (input din_valid, input din_data, output din_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serialises host words into the daisy-chained ccff flip-flops, MSB first. Generates the shift
// enable for the external prog_clk gate. Counts loaded bits and folds the bits leaving the
// chain tail into a parity bit.
module ccff_bitstream_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 20,
  parameter int CNT_W        = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                     prog_clk,
  input  logic                     pReset_n,
  input  logic                     start,
  ccff_bitstream_loader_if.slave   din,
  output logic                     ccff_head,
  output logic                     ccff_shift_en,
  input  logic                     ccff_tail,
  output logic                     busy,
  output logic                     config_done,
  output logic [CNT_W-1:0]         bit_count,
  output logic                     tail_parity
);

  localparam int IDX_W = $clog2(WORD_WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

  state_e                r_state;
  logic [WORD_WIDTH-1:0] r_shreg;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [CNT_W-1:0]      r_bit_count;
  logic                  r_tail_parity;

  state_e                w_state_d;
  logic [WORD_WIDTH-1:0] w_shreg_d;
  logic [IDX_W-1:0]      w_bit_idx_d;
  logic [CNT_W-1:0]      w_bit_count_d;
  logic                  w_tail_parity_d;

  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_last_bit;
  logic                  w_word_ready;
  logic                  w_chain_full;

  // bit_count never exceeds CHAIN_LENGTH-1 while shifting, so the increment cannot wrap.
  assign w_cnt_inc    = r_bit_count + CNT_W'(1);
  assign w_last_bit   = (r_bit_idx == IDX_W'(WORD_WIDTH - 1));
  assign w_chain_full = (w_cnt_inc == CNT_W'(CHAIN_LENGTH));
  // Request the next word on the final bit of a word, unless this edge completes the chain.
  assign w_word_ready = (r_state == StShift) && w_last_bit &&
                        (w_cnt_inc < CNT_W'(CHAIN_LENGTH));

  // Outputs are decoded from registered state only; din_valid never reaches ccff_head.
  assign din.din_ready  = (r_state == StLoad) || w_word_ready;
  assign ccff_shift_en  = (r_state == StShift);
  assign ccff_head      = (r_state == StShift) ? r_shreg[WORD_WIDTH-1] : 1'b0;
  assign busy           = (r_state == StLoad) || (r_state == StShift);
  assign config_done    = (r_state == StDone);
  assign bit_count      = r_bit_count;
  assign tail_parity    = r_tail_parity;

  // State register and datapath registers; asynchronous reset clears everything.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_state       <= StIdle;
      r_shreg       <= '0;
      r_bit_idx     <= '0;
      r_bit_count   <= '0;
      r_tail_parity <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_shreg       <= w_shreg_d;
      r_bit_idx     <= w_bit_idx_d;
      r_bit_count   <= w_bit_count_d;
      r_tail_parity <= w_tail_parity_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_d       = r_state;
    w_shreg_d       = r_shreg;
    w_bit_idx_d     = r_bit_idx;
    w_bit_count_d   = r_bit_count;
    w_tail_parity_d = r_tail_parity;

    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_d       = StLoad;
          w_bit_count_d   = '0;
          w_tail_parity_d = 1'b0;
        end
      end

      StLoad: begin
        if (din.din_valid) begin
          w_shreg_d   = din.din_data;
          w_bit_idx_d = '0;
          w_state_d   = StShift;
        end
      end

      StShift: begin
        w_bit_count_d   = w_cnt_inc;
        w_tail_parity_d = r_tail_parity ^ ccff_tail;
        w_shreg_d       = r_shreg << 1;
        w_bit_idx_d     = r_bit_idx + IDX_W'(1);
        if (w_chain_full) begin
          // Any unshifted bits of the current word are dropped.
          w_state_d = StDone;
        end else if (w_last_bit) begin
          if (din.din_valid) begin
            w_shreg_d   = din.din_data;
            w_bit_idx_d = '0;
          end else begin
            w_state_d = StLoad;
          end
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

endmodule
